// File: rtl/mem_stage_pkg.sv
// Shared field positions, codes and helpers for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned EX_MEM_W = 139;
  localparam int unsigned MEM_WB_W = 38;

  localparam int unsigned EXM_SD_LSB     = 0;
  localparam int unsigned EXM_ALU_LSB    = 32;
  localparam int unsigned EXM_RD_LSB     = 64;
  localparam int unsigned EXM_MEMREAD    = 69;
  localparam int unsigned EXM_MEMWRITE   = 70;
  localparam int unsigned EXM_REGWRITE   = 71;
  localparam int unsigned EXM_MTR_LSB    = 72;
  localparam int unsigned EXM_PC4_LSB    = 74;
  localparam int unsigned EXM_LUDATA_LSB = 106;
  localparam int unsigned EXM_LUOP       = 138;

  localparam int unsigned MWB_DATA_LSB = 0;
  localparam int unsigned MWB_RD_LSB   = 32;
  localparam int unsigned MWB_REGWRITE = 37;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_PC4  = 2'b10,
    MTR_ALU2 = 2'b11
  } mem_to_reg_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Writeback source select; an upper-immediate op overrides MemToReg.
  function automatic logic [XLEN-1:0] wb_select(
    input logic            lu_op,
    input logic [XLEN-1:0] lu_data,
    input logic [1:0]      mtr,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] load
  );
    logic [XLEN-1:0] res;
    res = alu;
    if (lu_op) begin
      res = lu_data;
    end else begin
      case (mtr)
        MTR_MEM: res = load;
        MTR_PC4: res = pc4;
        default: res = alu;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus sequencer: IDLE/BUSY FSM, timeout counter and held request registers.
module mem_bus_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             access_i,
  input  logic             aligned_i,
  input  logic             write_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [REG_W-1:0] wr_reg_i,
  input  logic             reg_write_i,
  input  logic [1:0]       mem_to_reg_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic [REG_W-1:0] wr_reg_o,
  output logic             reg_write_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             pass_c_o,
  output logic             issue_c_o,
  output logic             misalign_c_o,
  output logic             done_c_o,
  output logic             abort_c_o,
  output logic             stall_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_c;
  logic             idle_c;
  logic             busy_c;

  // Per-cycle decode; everything is masked while reset is held.
  always_comb begin
    last_c       = (cnt_q == CNT_W'(TIMEOUT - 1));
    idle_c       = !reset && (state_q == ST_IDLE);
    busy_c       = !reset && (state_q == ST_BUSY);
    pass_c_o     = idle_c && !access_i;
    issue_c_o    = idle_c && access_i && aligned_i;
    misalign_c_o = idle_c && access_i && !aligned_i;
    done_c_o     = busy_c && mem_ack_i;
    abort_c_o    = busy_c && !mem_ack_i && last_c;
    stall_c_o    = issue_c_o || (busy_c && !mem_ack_i && !last_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      wr_reg_o     <= '0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_i && aligned_i) begin
            state_q      <= ST_BUSY;
            cnt_q        <= '0;
            mem_req_o    <= 1'b1;
            mem_we_o     <= write_i;
            mem_addr_o   <= addr_i;
            mem_wdata_o  <= wdata_i;
            wr_reg_o     <= wr_reg_i;
            reg_write_o  <= reg_write_i && !write_i;
            mem_to_reg_o <= mem_to_reg_i;
          end
        end
        ST_BUSY: begin
          // An ack on the final cycle still completes the access.
          if (mem_ack_i || last_c) begin
            state_q   <= ST_IDLE;
            mem_req_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: unpacks EX_MEM, drives the data-memory bus and builds MEM_WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [EX_MEM_W-1:0] EX_MEM,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                stall,
  output logic                misalign,
  output logic                mem_err,
  output logic [REG_W-1:0]    EX_MEM_Rd,
  output logic [XLEN-1:0]     EX_MEM_RdData,
  output logic                EX_MEM_RegWrite,
  output logic [MEM_WB_W-1:0] MEM_WB
);

  logic [XLEN-1:0]     store_data, alu, pc4, lu_data;
  logic [REG_W-1:0]    wr_reg, wr_reg_q;
  logic [1:0]          mtr, mtr_q;
  logic                mem_read, mem_write, reg_write, reg_write_q, lu_op;
  logic                pass_c, issue_c, misalign_c, done_c, abort_c, stall_c;
  logic [XLEN-1:0]     pass_data, done_data;
  logic [MEM_WB_W-1:0] mem_wb_q;

  assign store_data = EX_MEM[EXM_SD_LSB +: XLEN];
  assign alu        = EX_MEM[EXM_ALU_LSB +: XLEN];
  assign wr_reg     = EX_MEM[EXM_RD_LSB +: REG_W];
  assign mem_read   = EX_MEM[EXM_MEMREAD];
  assign mem_write  = EX_MEM[EXM_MEMWRITE];
  assign reg_write  = EX_MEM[EXM_REGWRITE];
  assign mtr        = EX_MEM[EXM_MTR_LSB +: 2];
  assign pc4        = EX_MEM[EXM_PC4_LSB +: XLEN];
  assign lu_data    = EX_MEM[EXM_LUDATA_LSB +: XLEN];
  assign lu_op      = EX_MEM[EXM_LUOP];

  mem_bus_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .access_i     (mem_read || mem_write),
    .aligned_i    (alu[1:0] == 2'b00),
    .write_i      (mem_write),
    .addr_i       (alu),
    .wdata_i      (store_data),
    .wr_reg_i     (wr_reg),
    .reg_write_i  (reg_write),
    .mem_to_reg_i (mtr),
    .mem_ack_i    (mem_ack),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .wr_reg_o     (wr_reg_q),
    .reg_write_o  (reg_write_q),
    .mem_to_reg_o (mtr_q),
    .pass_c_o     (pass_c),
    .issue_c_o    (issue_c),
    .misalign_c_o (misalign_c),
    .done_c_o     (done_c),
    .abort_c_o    (abort_c),
    .stall_c_o    (stall_c)
  );

  // Forwarding view: the load-data slot falls back to the ALU value.
  always_comb begin
    pass_data     = wb_select(lu_op, lu_data, mtr, alu, pc4, mem_rdata);
    done_data     = wb_select(lu_op, lu_data, mtr_q, alu, pc4, mem_rdata);
    EX_MEM_RdData = wb_select(lu_op, lu_data, mtr, alu, pc4, alu);
  end

  assign EX_MEM_Rd       = wr_reg;
  assign EX_MEM_RegWrite = reg_write && !mem_read;
  assign stall           = stall_c;
  assign misalign        = misalign_c;
  assign mem_err         = abort_c;
  assign MEM_WB          = mem_wb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb_q <= '0;
    end else if (pass_c) begin
      mem_wb_q <= {reg_write, wr_reg, pass_data};
    end else if (misalign_c || abort_c) begin
      mem_wb_q <= '0;
    end else if (issue_c) begin
      mem_wb_q[MWB_REGWRITE] <= 1'b0;
    end else if (done_c) begin
      mem_wb_q <= {reg_write_q, wr_reg_q, done_data};
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a transaction-level reference model.
module tb_mem_stage;

  localparam int unsigned TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [138:0] EX_MEM;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         stall, misalign, mem_err;
  logic [4:0]   EX_MEM_Rd;
  logic [31:0]  EX_MEM_RdData;
  logic         EX_MEM_RegWrite;
  logic [37:0]  MEM_WB;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .EX_MEM          (EX_MEM),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .stall           (stall),
    .misalign        (misalign),
    .mem_err         (mem_err),
    .EX_MEM_Rd       (EX_MEM_Rd),
    .EX_MEM_RdData   (EX_MEM_RdData),
    .EX_MEM_RegWrite (EX_MEM_RegWrite),
    .MEM_WB          (MEM_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [138:0] mk(input logic [31:0] sd, input logic [31:0] alu,
                                      input logic [4:0] rd, input logic mr, input logic mw,
                                      input logic rw, input logic [1:0] mtr,
                                      input logic [31:0] pc4, input logic [31:0] lud,
                                      input logic luop);
    return {luop, lud, pc4, mtr, rw, mw, mr, rd, alu, sd};
  endfunction

  // Writeback value the instruction should produce, given the load data it saw.
  function automatic logic [37:0] model(input logic [138:0] ex, input logic [31:0] rdata);
    logic [31:0] alu, d;
    logic        acc;
    alu = ex[63:32];
    acc = ex[69] | ex[70];
    if (acc && (alu % 4 != 0)) return 38'd0;
    if (ex[138])             d = ex[137:106];
    else if (ex[73:72] == 1) d = rdata;
    else if (ex[73:72] == 2) d = ex[105:74];
    else                     d = alu;
    return {ex[71] & ~ex[70], ex[68:64], d};
  endfunction

  function automatic logic [31:0] fwd_model(input logic [138:0] ex);
    if (ex[138])         return ex[137:106];
    if (ex[73:72] == 2)  return ex[105:74];
    return ex[63:32];
  endfunction

  // Present one instruction; ack_at = BUSY cycle that carries mem_ack (0 = never).
  task automatic run_op(input logic [138:0] ex, input int ack_at, input logic [31:0] rd_val);
    logic        acc, aligned;
    logic [31:0] alu;
    alu     = ex[63:32];
    acc     = ex[69] | ex[70];
    aligned = (alu % 4 == 0);
    EX_MEM  = ex;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    #1;
    chk("fwd_rd", 64'(EX_MEM_Rd), 64'(ex[68:64]));
    chk("fwd_regwrite", 64'(EX_MEM_RegWrite), 64'(ex[71] & ~ex[69]));
    chk("fwd_data", 64'(EX_MEM_RdData), 64'(fwd_model(ex)));
    if (!acc) begin
      chk("pass_stall", 64'(stall), 64'd0);
      chk("pass_misalign", 64'(misalign), 64'd0);
      @(posedge clk); #1;
      chk("pass_wb", 64'(MEM_WB), 64'(model(ex, mem_rdata)));
      chk("pass_req", 64'(mem_req), 64'd0);
    end else if (!aligned) begin
      chk("mis_stall", 64'(stall), 64'd0);
      chk("mis_pulse", 64'(misalign), 64'd1);
      @(posedge clk); #1;
      chk("mis_req", 64'(mem_req), 64'd0);
      chk("mis_wb", 64'(MEM_WB), 64'd0);
    end else begin
      chk("issue_stall", 64'(stall), 64'd1);
      @(posedge clk); #1;
      chk("issue_req", 64'(mem_req), 64'd1);
      chk("issue_we", 64'(mem_we), 64'(ex[70]));
      chk("issue_wbrw", 64'(MEM_WB[37]), 64'd0);
      for (int cyc = 1; cyc <= int'(TIMEOUT); cyc++) begin
        if (cyc == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_val;
        end
        #1;
        chk("busy_addr", 64'(mem_addr), 64'(alu));
        if (ex[70]) chk("busy_wdata", 64'(mem_wdata), 64'(ex[31:0]));
        if (cyc == ack_at) begin
          chk("ack_stall", 64'(stall), 64'd0);
          chk("ack_err", 64'(mem_err), 64'd0);
          @(posedge clk); #1;
          mem_ack = 1'b0;
          chk("ack_wb", 64'(MEM_WB), 64'(model(ex, rd_val)));
          chk("ack_req", 64'(mem_req), 64'd0);
          break;
        end else if (cyc == int'(TIMEOUT)) begin
          chk("to_err", 64'(mem_err), 64'd1);
          chk("to_stall", 64'(stall), 64'd0);
          @(posedge clk); #1;
          chk("to_wb", 64'(MEM_WB), 64'd0);
          chk("to_req", 64'(mem_req), 64'd0);
        end else begin
          chk("busy_stall", 64'(stall), 64'd1);
          chk("busy_err", 64'(mem_err), 64'd0);
          chk("busy_req", 64'(mem_req), 64'd1);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    logic [138:0] ex;
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    EX_MEM    = mk(32'h0, 32'h100, 5'd8, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb", 64'(MEM_WB), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_err", 64'(mem_err | misalign), 64'd0);
    reset = 1'b0;

    // ALU op
    ex = mk(32'h0, 32'h12, 5'd5, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    run_op(ex, 0, 32'h0);
    chk("alu_const", 64'(MEM_WB), 64'({1'b1, 5'd5, 32'h12}));

    // Load with 3-cycle ack
    ex = mk(32'h0, 32'h100, 5'd8, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    run_op(ex, 3, 32'hDEADBEEF);
    chk("load_const", 64'(MEM_WB), 64'({1'b1, 5'd8, 32'hDEADBEEF}));

    // Store
    ex = mk(32'hA5A5A5A5, 32'h204, 5'd3, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    run_op(ex, 2, 32'h0);
    chk("store_rw", 64'(MEM_WB[37]), 64'd0);

    // Upper-immediate overrides MemToReg
    ex = mk(32'h0, 32'h40, 5'd9, 1'b0, 1'b0, 1'b1, 2'b10, 32'h1000, 32'h12340000, 1'b1);
    run_op(ex, 0, 32'h0);
    chk("lui_const", 64'(MEM_WB[31:0]), 64'h12340000);

    // Misaligned, timeout, ack on last cycle, read+write treated as write
    ex = mk(32'h0, 32'h102, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    run_op(ex, 0, 32'h0);
    ex = mk(32'h0, 32'h300, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    run_op(ex, 0, 32'h0);
    run_op(ex, int'(TIMEOUT), 32'h0BADF00D);
    ex = mk(32'h11223344, 32'h308, 5'd7, 1'b1, 1'b1, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    run_op(ex, 1, 32'h55667788);

    // mem_ack while idle is ignored
    EX_MEM  = mk(32'h0, 32'h7, 5'd2, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0, 32'h0, 1'b0);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack_req", 64'(mem_req), 64'd0);
    chk("idle_ack_wb", 64'(MEM_WB), 64'({1'b1, 5'd2, 32'h7}));

    // Reset while BUSY
    EX_MEM = mk(32'h0, 32'h400, 5'd10, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("rb_req", 64'(mem_req), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rb_req0", 64'(mem_req), 64'd0);
    chk("rb_wb0", 64'(MEM_WB), 64'd0);
    chk("rb_stall", 64'(stall), 64'd0);
    chk("rb_err", 64'(mem_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ex = mk(32'h0, 32'h99, 5'd11, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    run_op(ex, 0, 32'h0);

    // Randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic [31:0] alu;
      logic [1:0]  mtr;
      kind = int'($urandom_range(0, 3));
      alu  = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      mtr  = 2'($urandom_range(0, 3));
      if (kind == 0 && mtr == 2'b01) mtr = 2'b00;
      ex = mk($urandom, alu, 5'($urandom_range(0, 31)), kind == 1 || kind == 3,
              kind == 2 || kind == 3, 1'($urandom_range(0, 1)), mtr, $urandom, $urandom,
              1'($urandom_range(0, 1)));
      run_op(ex, int'($urandom_range(0, TIMEOUT)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
